inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, 32: instruction and address width.
REQ-002 Parameter DEPTH, 4: queue entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, 32'h0000_0000: first fetch address after reset.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  DATA_WIDTH  fetch byte address, bits[1:0] always 0.
REQ-008 imem_gnt  input  1  memory accepted request this cycle.
REQ-009 imem_rvalid  input  1  read data valid, strictly after gnt cycle.
REQ-010 imem_rdata  input  DATA_WIDTH  fetched instruction.
REQ-011 redirect_valid  input  1  taken branch or jump from execute; flush and refetch.
REQ-012 redirect_pc  input  DATA_WIDTH  new fetch address.
REQ-013 inst_valid  output  1  head entry valid toward decode.
REQ-014 inst_ready  input  1  decode consumes head entry.
REQ-015 inst_out  output  DATA_WIDTH  head instruction.
REQ-016 inst_pc  output  DATA_WIDTH  address of head instruction.
REQ-017 inst_pc_plus4  output  DATA_WIDTH  inst_pc + 4, modulo 2^DATA_WIDTH.

Function
REQ-018 FSM states are IDLE, REQ, WAIT and DROP.
- IDLE->REQ when credit is available.
- REQ->WAIT on gnt.
- WAIT->IDLE on rvalid; the response is pushed.
- DROP->IDLE on rvalid; the response is discarded.
REQ-019 Credit is defined as (count + outstanding) < DEPTH; outstanding is 1 in WAIT/DROP, else 0; at most one request is outstanding.
REQ-020 imem_req is 1 only in REQ; while waiting for gnt, imem_addr holds steady unless a redirect occurs.
REQ-021 On gnt, fetch_pc advances by 4 and wraps from 32'hFFFF_FFFC to 0.
REQ-022 A push writes {imem_addr of the granted request, imem_rdata} at the tail; inst_valid rises the cycle after rvalid, so latency is 1 cycle.
REQ-023 inst_valid = (count != 0); a pop occurs when inst_valid & inst_ready; the outputs show the head entry combinationally from queue registers.
REQ-024 Simultaneous push and pop leave count unchanged; a push never occurs at full, which credit guarantees.
REQ-025 Redirect effects in the next cycle:
- The queue is emptied (count=0) and pointers reset.
- fetch_pc becomes {redirect_pc[31:2],2'b00}.
- A pop in the same cycle is ignored.
REQ-026 Redirect in WAIT, or in REQ with gnt in the same cycle, moves to DROP; the in-flight response is discarded.
REQ-027 Redirect in REQ without gnt keeps imem_req=1, and imem_addr switches to the new PC next cycle.
REQ-028 Redirect in DROP keeps DROP and updates fetch_pc; redirect in IDLE updates fetch_pc only.
REQ-029 rvalid in IDLE or REQ is a protocol error and is ignored.

Reset
REQ-030 Asserting rst immediately forces:
- state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0.
- imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, inst_pc_plus4=0 (queue storage cleared).
REQ-031 Reset mid-transaction abandons any outstanding request; a response arriving after deassertion is ignored under REQ-029.
REQ-032 The first imem_req occurs in the second rising edge after rst deasserts (IDLE->REQ, then asserted).

Configuration
REQ-033 Macro IFQ_PERF_CNT_EN controls performance counters.
- Defined: the block adds output perf_fetch_cnt [31:0] (pushes) and output perf_flush_cnt [31:0] (redirects that discarded at least one entry or response). Both reset to 0, increment by 1, and wrap at 2^32.
- Undefined: the ports and logic are absent and the remaining behaviour is identical.

Verification
REQ-034 The bench shall cover these directed scenarios:
- V1 Reset, then gnt on the same cycle as req, rvalid 1 cycle later with 0x00500093 -> imem_addr=0x0; inst_valid with inst_pc=0x0, inst_out=0x00500093, inst_pc_plus4=0x4.
- V2 inst_ready=0, memory always grants -> exactly 4 entries (pc 0x0..0xC), then imem_req stays 0; one pop -> next req with addr 0x10.
- V3 Redirect to 0x40 while in WAIT for 0x8 -> rvalid data for 0x8 is dropped; queue empty; next imem_addr=0x40; first inst_pc=0x40.
- V4 Redirect to 0x23 with full queue and inst_ready=1 in the same cycle -> inst_valid=0 next cycle; fetch from 0x20.
- V5 redirect_pc=0xFFFFFFFC -> entries at 0xFFFFFFFC then 0x0; inst_pc_plus4 at head 0xFFFFFFFC equals 0x0.
- V6 rst asserted in WAIT with 2 entries queued -> outputs 0 asynchronously; a late rvalid after release pushes nothing; with IFQ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Instruction fetch queue bus bundle: instruction-memory request/response,
// execute-stage redirect and the decode-side instruction stream.
// The master modport is the fetch queue itself; slave is its environment.
interface inst_fetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_out;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic [DATA_WIDTH-1:0] inst_pc_plus4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues one outstanding fetch at a time, buffers
// up to DEPTH fetched instructions with their PCs, and flushes on redirect.
// Optional macro IFQ_PERF_CNT_EN adds push and flush performance counters.
module inst_fetch_queue #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  inst_fetch_queue_if.master      bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_flush_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e                state_q;
  logic                  imem_req_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] req_addr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  logic [DATA_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] pc4_mem_q  [DEPTH];

  logic redirect;
  logic granted;
  logic outstanding;
  logic credit;
  logic push;
  logic pop;

  // Low address bits of the redirect target are dropped by word alignment.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign redirect    = bus.redirect_valid;
  assign granted     = (state_q == S_REQ) && bus.imem_gnt;
  assign outstanding = (state_q == S_WAIT) || (state_q == S_DROP);
  assign credit      = (count_q + CW'(outstanding)) < CW'(DEPTH);
  // A redirect flushes the queue, so it overrides both a push and a pop.
  assign push        = (state_q == S_WAIT) && bus.imem_rvalid && !redirect;
  assign pop         = (count_q != '0) && bus.inst_ready && !redirect;

  // Fetch control FSM; imem_req is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      imem_req_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (credit) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            state_q    <= redirect ? S_DROP : S_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          // A redirect coinciding with the response discards it and needs no DROP.
          if (bus.imem_rvalid)  state_q <= S_IDLE;
          else if (redirect)    state_q <= S_DROP;
        end
        S_DROP: begin
          if (bus.imem_rvalid)  state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Next fetch address: redirect target (word aligned) or +4 on grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fetch_pc_d = fetch_pc_q;
    if (redirect)     fetch_pc_d = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
    else if (granted) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
  end

  // Queue occupancy and pointer bookkeeping; redirect empties the queue.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // Fetch PC, granted-request address and queue control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (granted) req_addr_q <= fetch_pc_q;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage: instruction, its PC and PC+4 written at the tail on push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset on purpose so the head outputs read zero during
      // reset; drop this reset if that visibility is ever not needed.
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
        pc4_mem_q[i]  <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_addr_q;
      pc4_mem_q[wr_ptr_q]  <= req_addr_q + DATA_WIDTH'(4);
    end
  end

  assign bus.imem_req      = imem_req_q;
  assign bus.imem_addr     = fetch_pc_q;
  assign bus.inst_valid    = (count_q != '0);
  assign bus.inst_out      = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc       = pc_mem_q[rd_ptr_q];
  assign bus.inst_pc_plus4 = pc4_mem_q[rd_ptr_q];

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;
  logic        flush_discard;

  // A flush counts only if it threw away a queued entry or an in-flight response.
  assign flush_discard = redirect &&
                         ((count_q != '0) || (state_q == S_WAIT) || granted);

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push)          perf_fetch_q <= perf_fetch_q + 32'd1;
      if (flush_discard) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue (DEPTH=4, RESET_PC=0).
// Build with +define+IFQ_PERF_CNT_EN to also check the performance counters.
module tb_inst_fetch_queue;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  inst_fetch_queue_if #(.DATA_WIDTH(32)) bus ();

  inst_fetch_queue #(
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for imem_req; an expired bound shows up as a failed check.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.imem_req && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.imem_req), 32'd1);
  endtask

  // Grant the pending request, then return data one cycle later.
  task automatic fetch_one(input logic [31:0] data);
    bus.imem_gnt    = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst                = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_req",   32'(bus.imem_req),   32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_out",   bus.inst_out,        32'd0);
    check("rst_pc",    bus.inst_pc,         32'd0);
    check("rst_pc4",   bus.inst_pc_plus4,   32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("idle_req", 32'(bus.imem_req), 32'd0);
    tick();

    // V1: first fetch from address 0, one-cycle response latency
    check("v1_req",  32'(bus.imem_req), 32'd1);
    check("v1_addr", bus.imem_addr,     32'h0000_0000);
    bus.imem_gnt    = 1'b1;
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    check("v1_valid_before", 32'(bus.inst_valid), 32'd0);
    tick();
    bus.imem_rvalid = 1'b0;
    check("v1_valid", 32'(bus.inst_valid), 32'd1);
    check("v1_pc",    bus.inst_pc,         32'h0000_0000);
    check("v1_out",   bus.inst_out,        32'h0050_0093);
    check("v1_pc4",   bus.inst_pc_plus4,   32'h0000_0004);

    // V2: fill to DEPTH with decode stalled, then one pop releases a fetch
    for (int i = 1; i < 4; i++) begin
      wait_req("v2_req");
      check("v2_addr", bus.imem_addr, 32'(i * 4));
      fetch_one(32'hA000_0000 + 32'(i * 4));
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      check("v2_full_noreq", 32'(bus.imem_req), 32'd0);
    end
    check("v2_head_pc", bus.inst_pc, 32'h0000_0000);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("v2_pop_pc",  bus.inst_pc,  32'h0000_0004);
    check("v2_pop_out", bus.inst_out, 32'hA000_0004);
    wait_req("v2_req_after_pop");
    check("v2_addr_after_pop", bus.imem_addr, 32'h0000_0010);
    fetch_one(32'hA000_0010);

    // V4: redirect to unaligned 0x23 on a full queue with a pop in the same cycle
    bus.inst_ready = 1'b1;
    redirect_to(32'h0000_0023);
    bus.inst_ready = 1'b0;
    check("v4_valid", 32'(bus.inst_valid), 32'd0);
    wait_req("v4_req");
    check("v4_addr", bus.imem_addr, 32'h0000_0020);

    // Redirect in REQ without grant: request held, address switches
    redirect_to(32'h0000_0008);
    check("req_redir_req",  32'(bus.imem_req), 32'd1);
    check("req_redir_addr", bus.imem_addr,     32'h0000_0008);

    // V3: redirect to 0x40 while waiting on 0x8; the late response is dropped
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    redirect_to(32'h0000_0040);
    check("v3_drop_noreq", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    check("v3_valid", 32'(bus.inst_valid), 32'd0);
    wait_req("v3_req");
    check("v3_addr", bus.imem_addr, 32'h0000_0040);
    fetch_one(32'hB000_0040);
    check("v3_pc",  bus.inst_pc,  32'h0000_0040);
    check("v3_out", bus.inst_out, 32'hB000_0040);

    // V5: fetch across the top of the address space
    redirect_to(32'hFFFF_FFFC);
    check("v5_valid", 32'(bus.inst_valid), 32'd0);
    wait_req("v5_req_hi");
    check("v5_addr_hi", bus.imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'hC0DE_0001);
    check("v5_pc_hi",  bus.inst_pc,       32'hFFFF_FFFC);
    check("v5_pc4_hi", bus.inst_pc_plus4, 32'h0000_0000);
    wait_req("v5_req_wrap");
    check("v5_addr_wrap", bus.imem_addr, 32'h0000_0000);
    fetch_one(32'hC0DE_0002);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("v5_pc_wrap",  bus.inst_pc,       32'h0000_0000);
    check("v5_out_wrap", bus.inst_out,      32'hC0DE_0002);
    check("v5_pc4_wrap", bus.inst_pc_plus4, 32'h0000_0004);

`ifdef IFQ_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd8);
    check("perf_flush", perf_flush_cnt, 32'd3);
`endif

    // V6: reset in WAIT with two entries queued, then a stray late response
    wait_req("v6_req");
    fetch_one(32'hD000_0004);
    wait_req("v6_req2");
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("v6_two_valid", 32'(bus.inst_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("v6_rst_req",   32'(bus.imem_req), 32'd0);
    check("v6_rst_valid", 32'(bus.inst_valid), 32'd0);
    check("v6_rst_out",   bus.inst_out,        32'd0);
    check("v6_rst_pc",    bus.inst_pc,         32'd0);
    check("v6_rst_pc4",   bus.inst_pc_plus4,   32'd0);
    check("v6_rst_addr",  bus.imem_addr,       32'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick();
    bus.imem_rvalid = 1'b0;
    check("v6_late_valid", 32'(bus.inst_valid), 32'd0);
    check("v6_late_req",   32'(bus.imem_req),   32'd1);
    check("v6_late_addr",  bus.imem_addr,       32'd0);
    tick();
    tick();
    check("v6_still_empty", 32'(bus.inst_valid), 32'd0);
`ifdef IFQ_PERF_CNT_EN
    check("v6_perf_fetch", perf_fetch_cnt, 32'd0);
    check("v6_perf_flush", perf_flush_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
